// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of predicted branches awaiting resolution.
// Produces predictor training pulses and mispredict redirects. Revision 1.0.
`default_nettype none

module branch_resolve_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [15:0] push_pc,
  input  logic        push_pred_taken,
  input  logic [15:0] push_pred_target,
  input  logic        resolve,
  input  logic        resolve_taken,
  input  logic [15:0] resolve_target,
  output logic        full,
  output logic        empty,
  output logic        load_BR,
  output logic        BR_taken,
  output logic [15:0] idex_PC,
  output logic        mispredict,
  output logic [15:0] redirect_pc,
  output logic        err
);

  localparam int unsigned c_aw = $clog2(DEPTH);
  localparam logic [c_aw-1:0] c_ptr_one = 1;
  localparam logic [c_aw:0]   c_depth   = DEPTH;

  logic [15:0]     r_pc     [DEPTH];
  logic            r_taken  [DEPTH];
  logic [15:0]     r_target [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;

  logic [15:0] w_head_pc;
  logic        w_head_taken;
  logic [15:0] w_head_target;
  logic        w_res_ok;
  logic        w_push_ok;
  logic        w_mis;
  logic        w_wr_en;

  assign full  = (r_count == c_depth);
  assign empty = (r_count == '0);

  assign w_head_pc     = r_pc[r_rd_ptr];
  assign w_head_taken  = r_taken[r_rd_ptr];
  assign w_head_target = r_target[r_rd_ptr];

  // A same-cycle pop frees a slot, so a full queue still accepts a push then.
  assign w_res_ok  = resolve && !empty;
  assign w_push_ok = push && (!full || w_res_ok);
  assign w_mis     = w_res_ok &&
                     ((w_head_taken != resolve_taken) ||
                      (w_head_taken && resolve_taken && (w_head_target != resolve_target)));
  // Pushes alongside a mispredict are wrong-path and never land.
  assign w_wr_en   = w_push_ok && !w_mis;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_pc[r_wr_ptr]     <= push_pc;
      r_taken[r_wr_ptr]  <= push_pred_taken;
      r_target[r_wr_ptr] <= push_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      load_BR     <= 1'b0;
      BR_taken    <= 1'b0;
      idex_PC     <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      err         <= 1'b0;
    end else begin
      load_BR    <= w_res_ok;
      mispredict <= w_mis;
      if (w_res_ok) begin
        BR_taken <= resolve_taken;
        idex_PC  <= w_head_pc;
      end
      if (w_mis) begin
        redirect_pc <= resolve_taken ? resolve_target : (w_head_pc + 16'd2);
      end
      if ((push && full && !w_res_ok) || (resolve && empty)) begin
        err <= 1'b1;
      end

      if (w_mis) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
        r_wr_ptr <= r_rd_ptr + c_ptr_one;
        r_count  <= '0;
      end else begin
        if (w_res_ok) r_rd_ptr <= r_rd_ptr + c_ptr_one;
        if (w_wr_en)  r_wr_ptr <= r_wr_ptr + c_ptr_one;
        r_count <= r_count + (c_aw+1)'(w_wr_en) - (c_aw+1)'(w_res_ok);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed vector table plus hand-written reset sequences.
// Revision 1.0.
`default_nettype none

module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        push = 1'b0;
  logic [15:0] push_pc = '0;
  logic        push_pred_taken = 1'b0;
  logic [15:0] push_pred_target = '0;
  logic        resolve = 1'b0;
  logic        resolve_taken = 1'b0;
  logic [15:0] resolve_target = '0;
  logic        full, empty, load_BR, BR_taken, mispredict, err;
  logic [15:0] idex_PC, redirect_pc;

  int n_pass = 0;
  int n_total = 0;

  branch_resolve_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .push(push), .push_pc(push_pc), .push_pred_taken(push_pred_taken),
    .push_pred_target(push_pred_target),
    .resolve(resolve), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .full(full), .empty(empty), .load_BR(load_BR), .BR_taken(BR_taken),
    .idex_PC(idex_PC), .mispredict(mispredict), .redirect_pc(redirect_pc), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic push; logic [15:0] ppc; logic pt; logic [15:0] ptg;
    logic res; logic rt; logic [15:0] rtg;
    logic load; logic taken; logic [15:0] ipc; logic mis; logic [15:0] redir;
    logic full; logic empty; logic err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int p, int ppc, int pt, int ptg, int r, int rt, int rtg,
                              int ld, int tk, int ipc, int ms, int rd, int fl, int em, int er);
    vec_t v;
    v.push = p[0]; v.ppc = 16'(ppc); v.pt = pt[0]; v.ptg = 16'(ptg);
    v.res = r[0]; v.rt = rt[0]; v.rtg = 16'(rtg);
    v.load = ld[0]; v.taken = tk[0]; v.ipc = 16'(ipc); v.mis = ms[0]; v.redir = 16'(rd);
    v.full = fl[0]; v.empty = em[0]; v.err = er[0];
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state.
    reset_n = 1'b0;
    step(); step();
    chk("rst load_BR", 16'(load_BR), 16'h0);
    chk("rst BR_taken", 16'(BR_taken), 16'h0);
    chk("rst idex_PC", idex_PC, 16'h0);
    chk("rst mispredict", 16'(mispredict), 16'h0);
    chk("rst redirect_pc", redirect_pc, 16'h0);
    chk("rst full", 16'(full), 16'h0);
    chk("rst empty", 16'(empty), 16'h1);
    chk("rst err", 16'(err), 16'h0);
    reset_n = 1'b1;

    // Correct taken resolve, direction mispredicts, PC wrap on redirect.
    vecs.push_back(mk(1,'h3000,1,'h3010, 0,0,0,       0,0,0,0,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,           1,1,'h3010,  1,1,'h3000,0,0,       0,1,0));
    vecs.push_back(mk(1,'h4000,1,'h4100, 0,0,0,       0,0,0,0,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,           1,0,0,       1,0,'h4000,1,'h4002,  0,1,0));
    vecs.push_back(mk(1,'hFFFE,1,'h0010, 0,0,0,       0,0,0,0,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,           1,0,0,       1,0,'hFFFE,1,'h0000,  0,1,0));
    // Flush: three entries, mispredict on the first while pushing a fourth.
    vecs.push_back(mk(1,'h1000,0,0,      0,0,0,       0,0,0,0,0,            0,0,0));
    vecs.push_back(mk(1,'h1010,0,0,      0,0,0,       0,0,0,0,0,            0,0,0));
    vecs.push_back(mk(1,'h1020,0,0,      0,0,0,       0,0,0,0,0,            0,0,0));
    vecs.push_back(mk(1,'h1030,0,0,      1,1,'h2000,  1,1,'h1000,1,'h2000,  0,1,0));
    vecs.push_back(mk(1,'h1040,1,'h1080, 0,0,0,       0,0,0,0,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,           1,1,'h1080,  1,1,'h1040,0,0,       0,1,0));
    // Fill to full, then a lone push is dropped with err.
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1,'h2000+2*k,0,0, 0,0,0, 0,0,0,0,0, (k==3)?1:0,0,0));
    vecs.push_back(mk(1,'h2008,0,0,      0,0,0,       0,0,0,0,0,            1,0,1));
    // Push + correct resolve while full, across pointer wrap.
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1,'h2100+2*k,0,0, 1,0,0,
                        1,0,(k<4)?('h2000+2*k):('h2100+2*(k-4)),0,0, 1,0,1));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0,0,0,0, 1,0,0, 1,0,'h2108+2*k,0,0, 0,(k==3)?1:0,1));
    // Resolve while empty, target-only mispredict, empty resolve with push.
    vecs.push_back(mk(0,0,0,0,           1,0,0,       0,0,0,0,0,            0,1,1));
    vecs.push_back(mk(1,'h5000,1,'h5010, 0,0,0,       0,0,0,0,0,            0,0,1));
    vecs.push_back(mk(0,0,0,0,           1,1,'h5020,  1,1,'h5000,1,'h5020,  0,1,1));
    vecs.push_back(mk(1,'h6000,0,0,      1,0,0,       0,0,0,0,0,            0,0,1));
    vecs.push_back(mk(0,0,0,0,           1,0,0,       1,0,'h6000,0,0,       0,1,1));

    foreach (vecs[i]) begin
      push = vecs[i].push; push_pc = vecs[i].ppc;
      push_pred_taken = vecs[i].pt; push_pred_target = vecs[i].ptg;
      resolve = vecs[i].res; resolve_taken = vecs[i].rt; resolve_target = vecs[i].rtg;
      step();
      chk($sformatf("v%0d load_BR", i), 16'(load_BR), 16'(vecs[i].load));
      chk($sformatf("v%0d mispredict", i), 16'(mispredict), 16'(vecs[i].mis));
      chk($sformatf("v%0d full", i), 16'(full), 16'(vecs[i].full));
      chk($sformatf("v%0d empty", i), 16'(empty), 16'(vecs[i].empty));
      chk($sformatf("v%0d err", i), 16'(err), 16'(vecs[i].err));
      if (vecs[i].load) begin
        chk($sformatf("v%0d BR_taken", i), 16'(BR_taken), 16'(vecs[i].taken));
        chk($sformatf("v%0d idex_PC", i), idex_PC, vecs[i].ipc);
      end
      if (vecs[i].mis) chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].redir);
    end

    // Reset asserted in the same cycle as a mispredicting resolve.
    push = 1'b1; push_pc = 16'h7000; push_pred_taken = 1'b0; push_pred_target = '0;
    resolve = 1'b0;
    step();
    push = 1'b0;
    resolve = 1'b1; resolve_taken = 1'b1; resolve_target = 16'h7777;
    reset_n = 1'b0;
    step();
    chk("mid-rst load_BR", 16'(load_BR), 16'h0);
    chk("mid-rst mispredict", 16'(mispredict), 16'h0);
    chk("mid-rst empty", 16'(empty), 16'h1);
    chk("mid-rst full", 16'(full), 16'h0);
    chk("mid-rst err", 16'(err), 16'h0);
    chk("mid-rst redirect_pc", redirect_pc, 16'h0);
    reset_n = 1'b1;
    resolve = 1'b0;

    // Entries pushed before reset must be gone: an empty resolve flags err.
    resolve = 1'b1; resolve_taken = 1'b0;
    step();
    resolve = 1'b0;
    chk("post-rst load_BR", 16'(load_BR), 16'h0);
    chk("post-rst err", 16'(err), 16'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order tracking queue between fetch and execute for conditional branches. Fetch pushes one entry per predicted branch (PC, predicted direction, predicted target). Execute resolves branches oldest-first. For each resolved branch the queue produces the predictor training pulse (`load_BR`, `BR_taken`, `idex_PC`) and, on a mispredict, a redirect PC plus a flush of all younger entries.

## Interface
Parameters:
- `DEPTH`, 4: number of in-flight branch entries; power of two, 2–16.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `push`  in  1  fetch has a predicted branch this cycle.
- `push_pc`  in  16  PC of the branch instruction.
- `push_pred_taken`  in  1  predicted direction (predictor `prediction`).
- `push_pred_target`  in  16  predicted target (predictor `target_address`).
- `resolve`  in  1  execute resolves the oldest outstanding branch this cycle.
- `resolve_taken`  in  1  actual direction.
- `resolve_target`  in  16  actual target address; only meaningful when `resolve_taken`=1.
- `full`  out  1  count == DEPTH (combinational from count).
- `empty`  out  1  count == 0 (combinational from count).
- `load_BR`  out  1  registered one-cycle training pulse to the predictor.
- `BR_taken`  out  1  registered actual direction accompanying `load_BR`.
- `idex_PC`  out  16  registered PC of the resolved branch accompanying `load_BR`.
- `mispredict`  out  1  registered one-cycle pulse; fetch must redirect and flush.
- `redirect_pc`  out  16  registered correct next PC, valid with `mispredict`.
- `err`  out  1  sticky error: push while full, or resolve while empty.

## Operation
- Storage: circular buffer of DEPTH entries {pc, pred_taken, pred_target}. Fields:
  - `wr_ptr`, `rd_ptr`: log2(DEPTH) bits each; wrap modulo DEPTH.
  - `count`: log2(DEPTH)+1 bits.
- Push accepted when `push`=1 and not full. The entry is written at `wr_ptr`, then `wr_ptr`+1.
- Resolve accepted when `resolve`=1 and not empty. It compares against the head entry at `rd_ptr`, then pops (`rd_ptr`+1).
- Mispredict condition:
  - (`pred_taken` != `resolve_taken`), or
  - (`pred_taken` & `resolve_taken` & `pred_target` != `resolve_target`).
- Redirect PC: `resolve_taken` ? `resolve_target` : head pc + 2. The addition is 16-bit and wraps modulo 2^16 (0xFFFE+2 = 0x0000).
- Every accepted resolve sets, in the next cycle:
  - `load_BR`=1
  - `BR_taken`=`resolve_taken`
  - `idex_PC`=head pc
- When an accepted resolve mispredicts:
  - `mispredict`=1 and `redirect_pc` are set in the next cycle.
  - The queue is flushed: `count`=0 and `wr_ptr`=`rd_ptr`=the post-pop `rd_ptr`.
  - Any push in the same cycle is dropped. The younger entries and the same-cycle push are all wrong-path.
- Simultaneous push and correct resolve:
  - Both are performed; `count` is unchanged.
  - This is legal when full, because the pop frees a slot in the same cycle. `full` does not block the push in that case.
- Push while full without a resolve: the push is dropped and `err` is set.
- Resolve while empty: ignored, `err` is set. A simultaneous push is still accepted.
- `err` clears only on reset.

## Timing
- Reset (`reset_n`=0 at a rising edge): pointers and count go to 0, so `empty`=1 and `full`=0. All outputs are 0: `load_BR`, `BR_taken`, `idex_PC`, `mispredict`, `redirect_pc`, `err`.
- Reset mid-operation discards all entries. Any pulse due on the following cycle is suppressed.
- Latency:
  - A push is visible as `count`/`full`/`empty` one cycle later.
  - A resolve produces `load_BR`/`mispredict` one cycle later.
  - Each pulse lasts exactly one cycle unless another resolve is accepted back-to-back.
- Throughput: one push and one resolve per cycle.
- `load_BR` and `BR_taken` are held at 0 / last value when there is no resolve. `BR_taken` and `idex_PC` only matter while `load_BR`=1.
- After a mispredict, the first push may occur in the cycle `mispredict` is high. It lands in the freshly flushed queue.

## Test plan
- Reset, then push PC=0x3000 (pred_taken=1, pred_target=0x3010). Next cycle resolve taken, target=0x3010 -> one cycle later: `load_BR`=1, `BR_taken`=1, `idex_PC`=0x3000, `mispredict`=0, `empty`=1.
- Push PC=0x4000 (pred_taken=1), then resolve not-taken -> `mispredict`=1 and `redirect_pc`=0x4002. Also check PC=0xFFFE -> `redirect_pc`=0x0000.
- Push 3 entries, then resolve the first as a direction mispredict while pushing a 4th -> `count`=0 after the edge, the 4th is dropped, `empty`=1. The next push lands at the head and resolves correctly.
- Fill DEPTH=4 entries -> `full`=1.
  - A push alone is dropped and sets `err`=1.
  - Then push+correct resolve in the same cycle -> `count` stays 4, and FIFO order is verified across pointer wrap over 8 more pairs.
- Resolve when empty -> no `load_BR`, `err`=1 (sticky). A target-only mispredict (both taken, target 0x5020 vs predicted 0x5010) -> `mispredict`=1, `redirect_pc`=0x5020.
- Assert `reset_n`=0 in the same cycle as a resolve -> the next cycle has `load_BR`=0, `mispredict`=0, `empty`=1, `err`=0.
